// File: rtl/m65c02_pkg.sv
// Shared definitions for the M65C02 status word: op encodings, flag indices,
// reset image and the ALU update-mask bit positions.
package m65c02_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_CLC = 4'd1,
        OP_SEC = 4'd2,
        OP_CLI = 4'd3,
        OP_SEI = 4'd4,
        OP_CLD = 4'd5,
        OP_SED = 4'd6,
        OP_CLV = 4'd7,
        OP_PLP = 4'd8,
        OP_RTI = 4'd9,
        OP_IRQ = 4'd10,
        OP_BRK = 4'd11
    } op_e;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_I = 2;
    localparam int FLG_D = 3;
    localparam int FLG_B = 4;
    localparam int FLG_M = 5;
    localparam int FLG_V = 6;
    localparam int FLG_N = 7;

    localparam logic [7:0] P_RST = 8'h34;

    localparam int UPD_NZ = 2;
    localparam int UPD_C  = 1;
    localparam int UPD_V  = 0;

    // Stack image of P: bit5 always set, bit4 distinguishes BRK from hardware interrupts.
    function automatic logic [7:0] push_image(input logic [7:0] p, input logic brk);
        logic [7:0] img;
        img        = p;
        img[FLG_M] = 1'b1;
        img[FLG_B] = brk;
        return img;
    endfunction

endpackage

// File: rtl/m65c02_flag_dec.sv
// Decodes the flag op into per-flag write enables/values and resolves it
// against the ALU update mask; the op always wins over the ALU on a shared flag.
module m65c02_flag_dec
    import m65c02_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic       alu_vld_i,
    input  logic [2:0] upd_i,
    input  logic [7:0] di_i,
    output logic [7:0] op_we_o,
    output logic [7:0] op_val_o,
    output logic [7:0] alu_we_o,
    output logic       conflict_o,
    output logic       irq_entry_o,
    output logic       brk_o
);

    logic [7:0] alu_raw;

    always_comb begin
        op_we_o  = '0;
        op_val_o = '0;
        case (op_i)
            OP_CLC: begin op_we_o[FLG_C] = 1'b1; op_val_o[FLG_C] = 1'b0; end
            OP_SEC: begin op_we_o[FLG_C] = 1'b1; op_val_o[FLG_C] = 1'b1; end
            OP_CLI: begin op_we_o[FLG_I] = 1'b1; op_val_o[FLG_I] = 1'b0; end
            OP_SEI: begin op_we_o[FLG_I] = 1'b1; op_val_o[FLG_I] = 1'b1; end
            OP_CLD: begin op_we_o[FLG_D] = 1'b1; op_val_o[FLG_D] = 1'b0; end
            OP_SED: begin op_we_o[FLG_D] = 1'b1; op_val_o[FLG_D] = 1'b1; end
            OP_CLV: begin op_we_o[FLG_V] = 1'b1; op_val_o[FLG_V] = 1'b0; end
            OP_PLP, OP_RTI: begin
                op_we_o  = '1;
                op_val_o = {di_i[7:6], 2'b11, di_i[3:0]};
            end
            // 65C02 interrupt entry also leaves decimal mode
            OP_IRQ, OP_BRK: begin
                op_we_o[FLG_I]  = 1'b1;
                op_val_o[FLG_I] = 1'b1;
                op_we_o[FLG_D]  = 1'b1;
                op_val_o[FLG_D] = 1'b0;
            end
            default: ;
        endcase

        alu_raw        = '0;
        alu_raw[FLG_N] = alu_vld_i & upd_i[UPD_NZ];
        alu_raw[FLG_Z] = alu_vld_i & upd_i[UPD_NZ];
        alu_raw[FLG_C] = alu_vld_i & upd_i[UPD_C];
        alu_raw[FLG_V] = alu_vld_i & upd_i[UPD_V];
    end

    assign alu_we_o    = alu_raw & ~op_we_o;
    assign conflict_o  = |(alu_raw & op_we_o);
    assign irq_entry_o = (op_i == OP_IRQ) || (op_i == OP_BRK);
    assign brk_o       = (op_i == OP_BRK);

endmodule

// File: rtl/m65c02_psw.sv
// M65C02 processor status word and ALU result latch: merges flag ops with
// adder results, captures the interrupt push image, flags conflicting writes.
module m65c02_psw
    import m65c02_pkg::*;
(
    input  logic       Clk,
    input  logic       nRst,
    input  logic       Rdy,
    input  logic       ALU_Vld,
    input  logic [2:0] Upd,
    input  logic [7:0] Sum,
    input  logic       Co,
    input  logic       OV,
    input  logic [3:0] Op,
    input  logic [7:0] DI,
    output logic       D,
    output logic       Ci,
    output logic [7:0] P,
    output logic [7:0] P_Push,
    output logic [7:0] Out,
    output logic       Out_Vld,
    output logic       Err
);

    logic [7:0] p_q, p_d;
    logic [7:0] out_q, push_q;
    logic       out_vld_q, err_q;
    logic [7:0] op_we, op_val, alu_we, alu_val;
    logic       conflict, irq_entry, is_brk;

    m65c02_flag_dec u_flag_dec (
        .op_i        (Op),
        .alu_vld_i   (ALU_Vld),
        .upd_i       (Upd),
        .di_i        (DI),
        .op_we_o     (op_we),
        .op_val_o    (op_val),
        .alu_we_o    (alu_we),
        .conflict_o  (conflict),
        .irq_entry_o (irq_entry),
        .brk_o       (is_brk)
    );

    always_comb begin
        alu_val        = '0;
        alu_val[FLG_N] = Sum[7];
        alu_val[FLG_Z] = (Sum == 8'h00);
        alu_val[FLG_C] = Co;
        alu_val[FLG_V] = OV;
        p_d = (p_q & ~(op_we | alu_we)) | (op_val & op_we) | (alu_val & alu_we);
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            p_q       <= P_RST;
            out_q     <= 8'h00;
            push_q    <= P_RST;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (Rdy) begin
            p_q <= p_d;
            if (ALU_Vld)
                out_q <= Sum;
            // push image reflects P before this cycle's interrupt-entry changes
            if (irq_entry)
                push_q <= push_image(p_q, is_brk);
            out_vld_q <= ALU_Vld;
            err_q     <= conflict;
        end else begin
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end
    end

    assign P       = p_q;
    assign D       = p_q[FLG_D];
    assign Ci      = p_q[FLG_C];
    assign P_Push  = push_q;
    assign Out     = out_q;
    assign Out_Vld = out_vld_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_m65c02_psw.sv
// Scoreboard bench for m65c02_psw: directed vectors push hand-computed
// expectations; a monitor pops one per issued cycle and compares outputs.
module tb_m65c02_psw;
    import m65c02_pkg::*;

    logic       Clk, nRst, Rdy, ALU_Vld, Co, OV;
    logic [2:0] Upd;
    logic [7:0] Sum, DI;
    logic [3:0] Op;
    logic       D, Ci, Out_Vld, Err;
    logic [7:0] P, P_Push, Out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [7:0] p;
        logic [7:0] out;
        logic       vld;
        logic       err;
        logic [7:0] push;
    } exp_t;

    exp_t sb[$];

    m65c02_psw dut (
        .Clk(Clk), .nRst(nRst), .Rdy(Rdy), .ALU_Vld(ALU_Vld), .Upd(Upd),
        .Sum(Sum), .Co(Co), .OV(OV), .Op(Op), .DI(DI),
        .D(D), .Ci(Ci), .P(P), .P_Push(P_Push), .Out(Out),
        .Out_Vld(Out_Vld), .Err(Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic rdy, input logic vld,
                        input logic [2:0] upd, input logic [7:0] sum,
                        input logic co, input logic ov, input logic [3:0] op,
                        input logic [7:0] di, input logic [7:0] ep,
                        input logic [7:0] eo, input logic ev, input logic ee,
                        input logic [7:0] epush);
        exp_t e;
        @(negedge Clk);
        Rdy = rdy; ALU_Vld = vld; Upd = upd; Sum = sum;
        Co = co; OV = ov; Op = op; DI = di;
        e.name = nm; e.p = ep; e.out = eo; e.vld = ev; e.err = ee; e.push = epush;
        sb.push_back(e);
    endtask

    // monitor: response to the vector driven at the previous negedge
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".P"},       P,                e.p);
                chk({e.name, ".D"},       {7'd0, D},        {7'd0, e.p[FLG_D]});
                chk({e.name, ".Ci"},      {7'd0, Ci},       {7'd0, e.p[FLG_C]});
                chk({e.name, ".Out_Vld"}, {7'd0, Out_Vld},  {7'd0, e.vld});
                chk({e.name, ".Out"},     Out,              e.out);
                chk({e.name, ".Err"},     {7'd0, Err},      {7'd0, e.err});
                chk({e.name, ".P_Push"},  P_Push,           e.push);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0; Rdy = 1'b1; ALU_Vld = 1'b1; Upd = 3'b111; Sum = 8'h55;
        Co = 1'b1; OV = 1'b1; Op = OP_NOP; DI = 8'h00;
        #23;
        chk("rst_init.P",       P,               8'h34);
        chk("rst_init.Out",     Out,             8'h00);
        chk("rst_init.Out_Vld", {7'd0, Out_Vld}, 8'h00);
        chk("rst_init.D_Ci",    {6'd0, D, Ci},   8'h00);
        @(negedge Clk);
        ALU_Vld = 1'b0; Upd = 3'b000;
        nRst = 1'b1;

        //    name       rdy vld upd     sum    co ov  op      di     P      Out    V  E  Push
        step("sed",      1, 0, 3'b000, 8'h00, 0, 0, OP_SED, 8'h00, 8'h3C, 8'h00, 0, 0, 8'h34);
        step("clc",      1, 0, 3'b000, 8'h00, 0, 0, OP_CLC, 8'h00, 8'h3C, 8'h00, 0, 0, 8'h34);
        step("dec_add",  1, 1, 3'b111, 8'h04, 1, 0, OP_NOP, 8'h00, 8'h3D, 8'h04, 1, 0, 8'h34);
        step("idle",     1, 0, 3'b000, 8'h00, 0, 0, OP_NOP, 8'h00, 8'h3D, 8'h04, 0, 0, 8'h34);
        step("zero",     1, 1, 3'b110, 8'h00, 1, 1, OP_NOP, 8'h00, 8'h3F, 8'h00, 1, 0, 8'h34);
        step("neg",      1, 1, 3'b100, 8'h80, 0, 0, OP_NOP, 8'h00, 8'hBD, 8'h80, 1, 0, 8'h34);
        step("set_v",    1, 1, 3'b001, 8'h01, 0, 1, OP_NOP, 8'h00, 8'hFD, 8'h01, 1, 0, 8'h34);
        step("clv_conf", 1, 1, 3'b001, 8'h02, 0, 1, OP_CLV, 8'h00, 8'hBD, 8'h02, 1, 1, 8'h34);
        step("cli_mrg",  1, 1, 3'b010, 8'h03, 0, 0, OP_CLI, 8'h00, 8'hB8, 8'h03, 1, 0, 8'h34);
        step("plp_conf", 1, 1, 3'b010, 8'h44, 0, 0, OP_PLP, 8'hC3, 8'hF3, 8'h44, 1, 1, 8'h34);
        step("rti",      1, 0, 3'b000, 8'h00, 0, 0, OP_RTI, 8'h00, 8'h30, 8'h44, 0, 0, 8'h34);
        step("sed2",     1, 0, 3'b000, 8'h00, 0, 0, OP_SED, 8'h00, 8'h38, 8'h44, 0, 0, 8'h34);
        step("sei",      1, 0, 3'b000, 8'h00, 0, 0, OP_SEI, 8'h00, 8'h3C, 8'h44, 0, 0, 8'h34);
        step("sec",      1, 0, 3'b000, 8'h00, 0, 0, OP_SEC, 8'h00, 8'h3D, 8'h44, 0, 0, 8'h34);
        step("irq",      1, 0, 3'b000, 8'h00, 0, 0, OP_IRQ, 8'h00, 8'h35, 8'h44, 0, 0, 8'h2D);
        step("sed3",     1, 0, 3'b000, 8'h00, 0, 0, OP_SED, 8'h00, 8'h3D, 8'h44, 0, 0, 8'h2D);
        step("brk",      1, 0, 3'b000, 8'h00, 0, 0, OP_BRK, 8'h00, 8'h35, 8'h44, 0, 0, 8'h3D);
        step("irq_alu",  1, 1, 3'b111, 8'h00, 0, 0, OP_IRQ, 8'h00, 8'h36, 8'h00, 1, 0, 8'h25);
        step("stall",    0, 1, 3'b111, 8'h99, 1, 1, OP_SEC, 8'h00, 8'h36, 8'h00, 0, 0, 8'h25);
        step("post_stl", 1, 0, 3'b000, 8'h00, 0, 0, OP_NOP, 8'h00, 8'h36, 8'h00, 0, 0, 8'h25);
        step("sec2",     1, 0, 3'b000, 8'h00, 0, 0, OP_SEC, 8'h00, 8'h37, 8'h00, 0, 0, 8'h25);
        step("v_only",   1, 1, 3'b001, 8'h5A, 0, 1, OP_NOP, 8'h00, 8'h77, 8'h5A, 1, 0, 8'h25);

        // asynchronous reset mid-cycle with an ALU update pending
        @(negedge Clk);
        Rdy = 1'b1; ALU_Vld = 1'b1; Upd = 3'b111; Sum = 8'h55; Co = 1'b1; OV = 1'b1; Op = OP_SED;
        #2;
        nRst = 1'b0;
        #1;
        chk("arst.P",       P,               8'h34);
        chk("arst.D_Ci",    {6'd0, D, Ci},   8'h00);
        chk("arst.Out_Vld", {7'd0, Out_Vld}, 8'h00);
        chk("arst.Out",     Out,             8'h00);
        chk("arst.P_Push",  P_Push,          8'h34);
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_hold.P",   P,   8'h34);
        chk("rst_hold.Out", Out, 8'h00);
        @(negedge Clk);
        ALU_Vld = 1'b0; Upd = 3'b000; Op = OP_NOP;
        nRst = 1'b1;

        step("post_rst", 1, 1, 3'b111, 8'h55, 0, 0, OP_NOP, 8'h00, 8'h34, 8'h55, 1, 0, 8'h34);
        step("idle2",    1, 0, 3'b000, 8'h00, 0, 0, OP_NOP, 8'h00, 8'h34, 8'h55, 0, 0, 8'h34);

        repeat (3) @(posedge Clk);
        #2;
        chk("sb_drain", 8'(sb.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
